// File: rtl/vending_request_arbiter_if.sv
// Panel-side and core-side signal bundle for vending_request_arbiter.
// slave: the arbiter. master: the surrounding system (panels plus core).
interface vending_request_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  // Panel requests
  logic [NUM_REQ-1:0]   req;
  logic [2*NUM_REQ-1:0] req_item;
  logic [2*NUM_REQ-1:0] req_coin_50;
  logic [2*NUM_REQ-1:0] req_coin_10;
  logic [2*NUM_REQ-1:0] req_coin_5;
  logic [2*NUM_REQ-1:0] req_coin_1;

  // Panel responses
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   done;
  logic                 err;
  logic                 busy;
  logic [1:0]           rsp_item;
  logic [2:0]           rsp_coin_50;
  logic [2:0]           rsp_coin_10;
  logic [2:0]           rsp_coin_5;
  logic [2:0]           rsp_coin_1;

  // Core inputs (driven by the arbiter)
  logic [1:0]           core_item_in;
  logic [1:0]           core_coin_50;
  logic [1:0]           core_coin_10;
  logic [1:0]           core_coin_5;
  logic [1:0]           core_coin_1;

  // Core outputs
  logic [1:0]           core_service;
  logic [1:0]           core_item_out;
  logic [2:0]           core_cout_50;
  logic [2:0]           core_cout_10;
  logic [2:0]           core_cout_5;
  logic [2:0]           core_cout_1;

  modport slave (
    input  req, req_item, req_coin_50, req_coin_10, req_coin_5, req_coin_1,
    output grant, done, err, busy,
    output rsp_item, rsp_coin_50, rsp_coin_10, rsp_coin_5, rsp_coin_1,
    output core_item_in, core_coin_50, core_coin_10, core_coin_5, core_coin_1,
    input  core_service, core_item_out, core_cout_50, core_cout_10, core_cout_5, core_cout_1
  );

  modport master (
    output req, req_item, req_coin_50, req_coin_10, req_coin_5, req_coin_1,
    input  grant, done, err, busy,
    input  rsp_item, rsp_coin_50, rsp_coin_10, rsp_coin_5, rsp_coin_1,
    input  core_item_in, core_coin_50, core_coin_10, core_coin_5, core_coin_1,
    output core_service, core_item_out, core_cout_50, core_cout_10, core_cout_5, core_cout_1
  );
endinterface

// File: rtl/vending_request_arbiter.sv
// Round-robin arbiter sharing one vendingMachine core between NUM_REQ panels.
// Flow: IDLE -> ISSUE (one-cycle item/coin presentation) -> WAIT (core BUSY
// until OFF) -> DONE (done pulse to winner) -> IDLE.
// Optional feature macro: VEND_ARB_TIMEOUT_EN adds a WAIT watchdog that aborts
// after TIMEOUT_CYCLES WAIT cycles with an empty result and an err pulse.
module vending_request_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                      clk,
  input logic                      reset,
  vending_request_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {SVC_OFF = 2'b00, SVC_ON = 2'b01, SVC_BUSY = 2'b10} service_t;

  state_t             state;
  logic [PTR_W-1:0]   rrPtr;
  logic [PTR_W-1:0]   winner;
  logic [NUM_REQ-1:0] eligible;
  logic               anyEligible;
  logic [PTR_W-1:0]   pick;
  logic [1:0]         selItem, sel50, sel10, sel5, sel1;

  logic [NUM_REQ-1:0] grantQ, doneQ;
  logic               busyQ;
  logic [1:0]         rspItemQ;
  logic [2:0]         rsp50Q, rsp10Q, rsp5Q, rsp1Q;
  logic [1:0]         coreItemQ, core50Q, core10Q, core5Q, core1Q;

`ifdef VEND_ARB_TIMEOUT_EN
  logic [7:0]         waitCnt;
  logic               errQ;
`endif

  // A panel is eligible when it requests with a real item code
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.req[i] && (bus.req_item[2*i +: 2] != 2'b00);
    end
  end

  // First eligible panel at or after rrPtr, wrapping
  always_comb begin
    int unsigned idx;
    idx         = 0;
    pick        = '0;
    anyEligible = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rrPtr) + k) % NUM_REQ;
      if (!anyEligible && eligible[idx]) begin
        anyEligible = 1'b1;
        pick        = PTR_W'(idx);
      end
    end
  end

  // Request fields of the selected panel
  always_comb begin
    selItem = bus.req_item[2*int'(pick) +: 2];
    sel50   = bus.req_coin_50[2*int'(pick) +: 2];
    sel10   = bus.req_coin_10[2*int'(pick) +: 2];
    sel5    = bus.req_coin_5[2*int'(pick) +: 2];
    sel1    = bus.req_coin_1[2*int'(pick) +: 2];
  end

  // Arbitration FSM with registered outputs.
  // The core_* registers double as the request latch: they are loaded on the
  // grant edge and hold the winner's values for the single ISSUE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rrPtr     <= '0;
      winner    <= '0;
      grantQ    <= '0;
      doneQ     <= '0;
      busyQ     <= 1'b0;
      rspItemQ  <= '0;
      rsp50Q    <= '0;
      rsp10Q    <= '0;
      rsp5Q     <= '0;
      rsp1Q     <= '0;
      coreItemQ <= '0;
      core50Q   <= '0;
      core10Q   <= '0;
      core5Q    <= '0;
      core1Q    <= '0;
`ifdef VEND_ARB_TIMEOUT_EN
      waitCnt   <= '0;
      errQ      <= 1'b0;
`endif
    end else begin
      doneQ <= '0;
`ifdef VEND_ARB_TIMEOUT_EN
      errQ  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.core_service == SVC_ON && anyEligible) begin
            winner    <= pick;
            grantQ    <= NUM_REQ'(1) << pick;
            busyQ     <= 1'b1;
            coreItemQ <= selItem;
            core50Q   <= sel50;
            core10Q   <= sel10;
            core5Q    <= sel5;
            core1Q    <= sel1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          coreItemQ <= '0;
          core50Q   <= '0;
          core10Q   <= '0;
          core5Q    <= '0;
          core1Q    <= '0;
`ifdef VEND_ARB_TIMEOUT_EN
          waitCnt   <= '0;
`endif
          state     <= WAIT;
        end
        WAIT: begin
          if (bus.core_service == SVC_OFF) begin
            rspItemQ <= bus.core_item_out;
            rsp50Q   <= bus.core_cout_50;
            rsp10Q   <= bus.core_cout_10;
            rsp5Q    <= bus.core_cout_5;
            rsp1Q    <= bus.core_cout_1;
            doneQ    <= NUM_REQ'(1) << winner;
            state    <= DONE;
          end
`ifdef VEND_ARB_TIMEOUT_EN
          else if (waitCnt == 8'(TIMEOUT_CYCLES - 1)) begin
            rspItemQ <= '0;
            rsp50Q   <= '0;
            rsp10Q   <= '0;
            rsp5Q    <= '0;
            rsp1Q    <= '0;
            doneQ    <= NUM_REQ'(1) << winner;
            errQ     <= 1'b1;
            state    <= DONE;
          end else begin
            waitCnt  <= waitCnt + 8'd1;
          end
`endif
        end
        DONE: begin
          grantQ <= '0;
          busyQ  <= 1'b0;
          rrPtr  <= PTR_W'((32'(winner) + 1) % NUM_REQ);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant        = grantQ;
  assign bus.done         = doneQ;
  assign bus.busy         = busyQ;
  assign bus.rsp_item     = rspItemQ;
  assign bus.rsp_coin_50  = rsp50Q;
  assign bus.rsp_coin_10  = rsp10Q;
  assign bus.rsp_coin_5   = rsp5Q;
  assign bus.rsp_coin_1   = rsp1Q;
  assign bus.core_item_in = coreItemQ;
  assign bus.core_coin_50 = core50Q;
  assign bus.core_coin_10 = core10Q;
  assign bus.core_coin_5  = core5Q;
  assign bus.core_coin_1  = core1Q;
`ifdef VEND_ARB_TIMEOUT_EN
  assign bus.err          = errQ;
`else
  assign bus.err          = 1'b0;
`endif
endmodule

// File: tb/tb_vending_request_arbiter.sv
// Bench for vending_request_arbiter: stub vending core plus a transaction-level
// reference model (round-robin pick, change computation, done timing).
`timescale 1ns/1ps
module tb_vending_request_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned TO = 8;
`ifdef VEND_ARB_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vending_request_arbiter_if #(.NUM_REQ(N)) bus ();
  vending_request_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Price list and greedy change, returns {item, n50, n10, n5, n1}
  function automatic logic [13:0] vend(input logic [1:0] item, input logic [1:0] c50,
                                       input logic [1:0] c10, input logic [1:0] c5,
                                       input logic [1:0] c1);
    int total, cost, chg, n50, n10, n5;
    logic [1:0] outItem;
    total = 50*int'(c50) + 10*int'(c10) + 5*int'(c5) + int'(c1);
    case (item)
      2'd1:    cost = 8;
      2'd2:    cost = 15;
      2'd3:    cost = 22;
      default: cost = 0;
    endcase
    if (item != 2'd0 && total >= cost) begin outItem = item; chg = total - cost; end
    else begin outItem = 2'd0; chg = total; end
    n50 = chg / 50; chg -= n50 * 50;
    n10 = chg / 10; chg -= n10 * 10;
    n5  = chg / 5;  chg -= n5 * 5;
    return {outItem, 3'(n50), 3'(n10), 3'(n5), 3'(chg)};
  endfunction

  // Stub core: ON -> BUSY (1..4 cycles, or held while stubHang) -> OFF (1 cycle) -> ON
  logic [1:0]  stubSvc;
  logic [13:0] stubRes;
  int          stubCnt;
  bit          stubHang = 1'b0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      stubSvc <= 2'b01; stubRes <= '0; stubCnt <= 0;
    end else if (stubSvc == 2'b01) begin
      if (bus.core_item_in != 2'b00) begin
        stubRes <= vend(bus.core_item_in, bus.core_coin_50, bus.core_coin_10,
                        bus.core_coin_5, bus.core_coin_1);
        stubCnt <= int'($urandom_range(1, 4));
        stubSvc <= 2'b10;
      end
    end else if (stubSvc == 2'b10) begin
      if (!stubHang) begin
        if (stubCnt <= 1) stubSvc <= 2'b00;
        else stubCnt <= stubCnt - 1;
      end
    end else begin
      stubSvc <= 2'b01;
    end
  end
  assign bus.core_service = stubSvc;
  // Outputs are garbage outside the OFF cycle so a mistimed capture shows up
  assign {bus.core_item_out, bus.core_cout_50, bus.core_cout_10, bus.core_cout_5, bus.core_cout_1} =
    (stubSvc == 2'b00) ? stubRes : ~stubRes;

  // Panel state and reference model
  bit          pend [N];
  logic [1:0]  pItem[N], p50[N], p10[N], p5[N], p1[N];
  int          rrPtr = 0, win = 0, sinceGrant = 0, errSeen = 0;
  bit          inFlight = 0, justDone = 0, randomOn = 0;
  logic [9:0]  winData;
  logic [13:0] winRsp, expRsp = '0;
  logic [N-1:0] eligPrev;
  bit          coreOnPrev, coreOffPrev;
  int          obsDone[$];

  function automatic int pickNext(input logic [N-1:0] elig, input int ptr);
    for (int k = 0; k < int'(N); k++) if (elig[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  task automatic setReq(input int i, input logic [1:0] it, input logic [1:0] a,
                        input logic [1:0] b, input logic [1:0] c, input logic [1:0] d);
    pend[i] = 1'b1; pItem[i] = it; p50[i] = a; p10[i] = b; p5[i] = c; p1[i] = d;
  endtask

  task automatic drive();
    for (int i = 0; i < int'(N); i++) begin
      bus.req[i]               = pend[i];
      bus.req_item[2*i +: 2]    = pItem[i];
      bus.req_coin_50[2*i +: 2] = p50[i];
      bus.req_coin_10[2*i +: 2] = p10[i];
      bus.req_coin_5[2*i +: 2]  = p5[i];
      bus.req_coin_1[2*i +: 2]  = p1[i];
      eligPrev[i] = pend[i] && (pItem[i] != 2'b00);
    end
    coreOnPrev  = (bus.core_service == 2'b01);
    coreOffPrev = (bus.core_service == 2'b00);
  endtask

  task automatic randomPanels();
    for (int i = 0; i < int'(N); i++) begin
      if (inFlight && i == win) begin
        // Post-grant changes to the winner's fields must be ignored
        if ($urandom_range(0, 3) == 0) begin
          p50[i] = 2'($urandom); p10[i] = 2'($urandom); p5[i] = 2'($urandom); p1[i] = 2'($urandom);
        end
      end else if (!pend[i]) begin
        if ($urandom_range(0, 3) == 0)
          setReq(i, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      end else if (pItem[i] == 2'b00 && $urandom_range(0, 7) == 0) begin
        pend[i] = 1'b0;
      end
    end
  endtask

  task automatic evaluate();
    bit issueNow, expDone, expErr;
    issueNow = 1'b0;
    if (inFlight) sinceGrant++;
    else if (!justDone && coreOnPrev && eligPrev != '0) begin
      win        = pickNext(eligPrev, rrPtr);
      inFlight   = 1'b1;
      issueNow   = 1'b1;
      sinceGrant = 0;
      winData    = {pItem[win], p50[win], p10[win], p5[win], p1[win]};
      winRsp     = vend(pItem[win], p50[win], p10[win], p5[win], p1[win]);
    end
    justDone = 1'b0;
    expDone  = inFlight && !issueNow &&
               (stubHang ? (WD_EN && sinceGrant == int'(TO) + 1) : coreOffPrev);
    expErr   = expDone && stubHang;
    if (bus.done != '0) for (int i = 0; i < int'(N); i++) if (bus.done[i]) obsDone.push_back(i);
    if (bus.err) errSeen++;
    checkValue("grant", 32'(bus.grant), inFlight ? 32'(1) << win : 32'd0);
    checkValue("busy", 32'(bus.busy), 32'(inFlight));
    checkValue("core_bus", {bus.core_item_in, bus.core_coin_50, bus.core_coin_10,
                            bus.core_coin_5, bus.core_coin_1}, issueNow ? 32'(winData) : 32'd0);
    checkValue("done", 32'(bus.done), expDone ? 32'(1) << win : 32'd0);
    checkValue("err", 32'(bus.err), 32'(expErr));
    if (expDone) expRsp = expErr ? 14'd0 : winRsp;
    checkValue("rsp", {bus.rsp_item, bus.rsp_coin_50, bus.rsp_coin_10, bus.rsp_coin_5,
                       bus.rsp_coin_1}, 32'(expRsp));
    if (expDone) begin
      rrPtr = (win + 1) % N; pend[win] = 1'b0; inFlight = 1'b0; justDone = 1'b1;
    end
    if (inFlight && sinceGrant > 200) begin
      checkValue("done_wait", 32'(sinceGrant), 32'd0);
      inFlight = 1'b0;
    end
  endtask

  task automatic cycleBody();
    if (randomOn) randomPanels();
    drive();
    @(posedge clk); #1;
    evaluate();
  endtask

  task automatic step();
    @(negedge clk);
    cycleBody();
  endtask

  task automatic runN(input int n);
    repeat (n) step();
  endtask

  task automatic checkAllZero(input string tag);
    checkValue({tag, "_ctl"}, {bus.grant, bus.done, bus.err, bus.busy}, 32'd0);
    checkValue({tag, "_data"}, {bus.rsp_item, bus.rsp_coin_50, bus.rsp_coin_10, bus.rsp_coin_5,
                                bus.rsp_coin_1, bus.core_item_in, bus.core_coin_50,
                                bus.core_coin_10, bus.core_coin_5, bus.core_coin_1}, 32'd0);
  endtask

  task automatic resetModel();
    inFlight = 1'b0; justDone = 1'b0; rrPtr = 0; expRsp = '0; sinceGrant = 0;
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) begin
      pend[i] = 1'b0; pItem[i] = '0; p50[i] = '0; p10[i] = '0; p5[i] = '0; p1[i] = '0;
    end
    drive();
    repeat (3) @(posedge clk);
    #1 checkAllZero("reset_state");
    @(negedge clk) reset = 1'b1;
    cycleBody();

    // Two simultaneous requests from rrPtr=0: panel 1 then panel 2
    setReq(1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0);
    setReq(2, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0);
    obsDone.delete();
    runN(30);
    checkValue("t2_count", 32'(obsDone.size()), 32'd2);
    if (obsDone.size() == 2) begin
      checkValue("t2_first", 32'(obsDone[0]), 32'd1);
      checkValue("t2_second", 32'(obsDone[1]), 32'd2);
    end

    // Item A with one NTD10: two NTD1 back
    setReq(0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0);
    runN(15);
    checkValue("t1_rsp", {bus.rsp_item, bus.rsp_coin_50, bus.rsp_coin_10, bus.rsp_coin_5,
                          bus.rsp_coin_1}, 32'b01_000_000_000_010);

    // Item C with one NTD10: refund
    obsDone.delete();
    setReq(3, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0);
    runN(15);
    checkValue("t3_rsp", {bus.rsp_item, bus.rsp_coin_50, bus.rsp_coin_10, bus.rsp_coin_5,
                          bus.rsp_coin_1}, 32'b00_000_001_000_000);
    checkValue("t3_winner", 32'(obsDone.size() == 1 ? obsDone[0] : -1), 32'd3);

    // Item 00 is never granted
    obsDone.delete();
    setReq(0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0);
    runN(20);
    checkValue("t4_no_done", 32'(obsDone.size()), 32'd0);
    pend[0] = 1'b0;

    // Reset during WAIT drops the transaction; request is re-served afterwards
    stubHang = 1'b1;
    setReq(1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0);
    for (int k = 0; k < 20 && !(inFlight && sinceGrant >= 2); k++) step();
    checkValue("t5_in_wait", 32'(inFlight), 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 checkAllZero("t5_reset");
    resetModel();
    stubHang = 1'b0;
    obsDone.delete();
    repeat (3) begin
      @(posedge clk); #1;
      checkValue("t5_no_done", 32'(bus.done), 32'd0);
    end
    @(negedge clk) reset = 1'b1;
    cycleBody();
    runN(15);
    checkValue("t5_served", 32'(obsDone.size()), 32'd1);

`ifdef VEND_ARB_TIMEOUT_EN
    // Core stuck in BUSY: watchdog abort with err
    errSeen  = 0;
    stubHang = 1'b1;
    setReq(2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0);
    runN(14);
    checkValue("t6_err_seen", 32'(errSeen), 32'd1);
    stubHang = 1'b0;
    runN(10);
`endif

    // Randomized traffic
    randomOn = 1'b1;
    runN(3000);
    randomOn = 1'b0;
    for (int i = 0; i < int'(N); i++) pend[i] = 1'b0;
    runN(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
